// File: rtl/if_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch front end.
// Contents: fetch FSM state encoding, default fetch parameters and the
// queue entry layout {pc, instr} carried from fetch to decode.
package if_prefetch_queue_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  localparam int          PC_STEP_DFLT  = 4;
  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries.
// Ports:
//   clk, reset      : clock, async active-high reset
//   flush           : empties the queue; overrides push/pop in that cycle
//   push, push_data : write one entry
//   pop             : retire the head entry
//   head_valid      : queue not empty
//   head_data       : head entry, reads 0 when empty
//   count           : occupied entries (0..DEPTH)
module if_sync_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output logic          head_valid,
  output fetch_entry_t  head_data,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && (count != FULL_C);
  assign pop_ok  = pop && (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one word request
// at a time to instruction memory (req/ack) and queues returned words with
// their PCs for decode (valid/ready). A redirect flushes the queue,
// retargets the PC and discards any in-flight response.
// Ports:
//   clk, reset                  : clock, async active-high reset
//   imem_req/addr, ack/rdata    : instruction memory handshake
//   instr_valid/ready/data/pc   : decode interface (queue head)
//   redirect_valid, redirect_pc : flush and retarget
//   fetch_pc                    : next address to be requested
//   q_count                     : occupied queue entries
//
// state      | meaning
// FETCH_IDLE | no request outstanding
// FETCH_WAIT | request for imem_addr outstanding, response will be queued
// FETCH_DROP | request outstanding, response will be discarded
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
  parameter int          PC_STEP  = PC_STEP_DFLT
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr_data,
  output logic [31:0]              instr_pc,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              fetch_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int            CW     = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  fetch_state_e  state;
  fetch_state_e  state_nxt;
  logic          push_en;
  logic          pop_en;
  logic          launch;
  logic          credit;
  logic [CW-1:0] q_next;
  fetch_entry_t  head;

  // Occupancy after this cycle's push/pop; a new request is only issued
  // when its response is guaranteed a free slot.
  always_comb begin
    q_next = q_count;
    case ({push_en, pop_en})
      2'b10:   q_next = q_count + 1'b1;
      2'b01:   q_next = q_count - 1'b1;
      default: q_next = q_count;
    endcase
  end

  assign credit = (q_next < FULL_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = (state != FETCH_IDLE && !imem_ack) ? FETCH_DROP : FETCH_IDLE;
    end else begin
      case (state)
        FETCH_IDLE: if (launch) state_nxt = FETCH_WAIT;
        FETCH_WAIT: if (imem_ack) state_nxt = credit ? FETCH_WAIT : FETCH_IDLE;
        FETCH_DROP: if (imem_ack) state_nxt = FETCH_IDLE;
        default:    state_nxt = FETCH_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req = (state != FETCH_IDLE);
    push_en  = (state == FETCH_WAIT) && imem_ack && !redirect_valid;
    pop_en   = instr_valid && instr_ready && !redirect_valid;
    launch   = !redirect_valid && credit &&
               ((state == FETCH_IDLE) || ((state == FETCH_WAIT) && imem_ack));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'h3;
    end else if (launch) begin
      imem_addr <= fetch_pc;
      fetch_pc  <= fetch_pc + 32'(PC_STEP);
    end
  end

  if_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push_en),
    .push_data  ('{pc: imem_addr, instr: imem_rdata}),
    .pop        (pop_en),
    .head_valid (instr_valid),
    .head_data  (head),
    .count      (q_count)
  );

  assign instr_data = head.instr;
  assign instr_pc   = head.pc;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a simple instruction memory
// model (auto ack after a programmable latency, or manually driven ack).
module tb_if_prefetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;
  logic [2:0]  q_count;

  int tests_run;
  int tests_failed;

  logic mem_auto;
  logic ack_manual;
  int   mem_lat;
  int   mem_cnt;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_pc       (fetch_pc),
    .q_count        (q_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign imem_ack   = mem_auto ? (imem_req && (mem_cnt >= mem_lat)) : ack_manual;
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  always @(posedge clk or posedge reset) begin
    if (reset)                      mem_cnt <= 0;
    else if (!imem_req || imem_ack) mem_cnt <= 0;
    else                            mem_cnt <= mem_cnt + 1;
  end

  // Leaves the bench on a negedge with reset just released; the n-th
  // following negedge sits after the n-th rising edge out of reset.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got %b exp 0", imem_req); end
    tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    tests_run++; if (fetch_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_fetch_pc got %h exp 0", fetch_pc); end
    tests_run++; if (q_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", q_count); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    tests_run++; if (instr_data !== 32'h0) begin tests_failed++; $display("FAIL reset_data got %h exp 0", instr_data); end
    tests_run++; if (instr_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h exp 0", instr_pc); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    mem_auto = 1'b1; mem_lat = 0; instr_ready = 1'b1;
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (n - 1))) begin
        tests_failed++; $display("FAIL zw_addr n=%0d got req=%b addr=%h exp 1/%h", n, imem_req, imem_addr, 32'(4 * (n - 1)));
      end
      if (n >= 2) begin
        exp_pc = 32'(4 * (n - 2));
        tests_run++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== (exp_pc ^ 32'hA5A5_0000) || q_count !== 3'd1) begin
          tests_failed++; $display("FAIL zw_head n=%0d got v=%b pc=%h d=%h cnt=%0d exp 1/%h/%h/1", n, instr_valid, instr_pc, instr_data, q_count, exp_pc, exp_pc ^ 32'hA5A5_0000);
        end
      end else begin
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL zw_first_valid got %b exp 0", instr_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    mem_auto = 1'b1; mem_lat = 0; instr_ready = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    tests_run++; if (q_count !== 3'd4) begin tests_failed++; $display("FAIL bp_count got %0d exp 4", q_count); end
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_req got %b exp 0", imem_req); end
    tests_run++; if (fetch_pc !== 32'd16) begin tests_failed++; $display("FAIL bp_fetch_pc got %h exp 10", fetch_pc); end
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_pc = 32'(4 * i);
      tests_run++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== (exp_pc ^ 32'hA5A5_0000)) begin
        tests_failed++; $display("FAIL bp_drain i=%0d got v=%b pc=%h d=%h exp pc %h", i, instr_valid, instr_pc, instr_data, exp_pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_latency();
    mem_auto = 1'b1; mem_lat = 2; instr_ready = 1'b1;
    do_reset();
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      tests_run++; if (q_count > 3'd4) begin tests_failed++; $display("FAIL lat_overflow n=%0d got %0d exp <=4", n, q_count); end
      if (n <= 3) begin
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
          tests_failed++; $display("FAIL lat_hold0 n=%0d got req=%b addr=%h v=%b exp 1/0/0", n, imem_req, imem_addr, instr_valid);
        end
      end else if (n == 4 || n == 7) begin
        tests_run++; if (imem_addr !== 32'((n == 4) ? 4 : 8) || instr_valid !== 1'b1 || instr_pc !== 32'((n == 4) ? 0 : 4) || q_count !== 3'd1) begin
          tests_failed++; $display("FAIL lat_push n=%0d got addr=%h v=%b pc=%h cnt=%0d", n, imem_addr, instr_valid, instr_pc, q_count);
        end
      end else begin
        tests_run++; if (imem_addr !== 32'h4 || instr_valid !== 1'b0 || q_count !== 3'd0) begin
          tests_failed++; $display("FAIL lat_single_push n=%0d got addr=%h v=%b cnt=%0d exp 4/0/0", n, imem_addr, instr_valid, q_count);
        end
      end
    end
  endtask

  task automatic test_redirect_drop();
    mem_auto = 1'b0; ack_manual = 1'b0; instr_ready = 1'b0;
    do_reset();
    @(negedge clk); ack_manual = 1'b1;
    repeat (2) @(negedge clk); ack_manual = 1'b0;
    tests_run++; if (q_count !== 3'd2 || imem_addr !== 32'h8) begin tests_failed++; $display("FAIL rd_setup got cnt=%0d addr=%h exp 2/8", q_count, imem_addr); end
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk); redirect_valid = 1'b0;
    tests_run++; if (q_count !== 3'd0 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_flush got cnt=%0d v=%b exp 0/0", q_count, instr_valid); end
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || fetch_pc !== 32'h100) begin
      tests_failed++; $display("FAIL rd_drop got req=%b addr=%h fpc=%h exp 1/8/100", imem_req, imem_addr, fetch_pc);
    end
    @(negedge clk); ack_manual = 1'b1;
    @(negedge clk); ack_manual = 1'b0;
    tests_run++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || q_count !== 3'd0) begin
      tests_failed++; $display("FAIL rd_discard got req=%b v=%b cnt=%0d exp 0/0/0", imem_req, instr_valid, q_count);
    end
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_pc !== 32'h104 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rd_refetch got req=%b addr=%h fpc=%h v=%b exp 1/100/104/0", imem_req, imem_addr, fetch_pc, instr_valid);
    end
  endtask

  // Continues from the state left by test_redirect_drop (WAIT on 0x100).
  task automatic test_redirect_ack();
    ack_manual = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk); ack_manual = 1'b0; redirect_valid = 1'b0;
    tests_run++; if (imem_req !== 1'b0 || q_count !== 3'd0 || fetch_pc !== 32'h200) begin
      tests_failed++; $display("FAIL ra_same_cycle got req=%b cnt=%0d fpc=%h exp 0/0/200", imem_req, q_count, fetch_pc);
    end
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL ra_refetch got req=%b addr=%h v=%b exp 1/200/0", imem_req, imem_addr, instr_valid);
    end
    ack_manual = 1'b1;
    repeat (2) @(negedge clk); ack_manual = 1'b0;
    tests_run++; if (q_count !== 3'd2 || instr_pc !== 32'h200) begin tests_failed++; $display("FAIL ra_fill got cnt=%0d pc=%h exp 2/200", q_count, instr_pc); end
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(negedge clk); instr_ready = 1'b0; redirect_valid = 1'b0;
    tests_run++; if (q_count !== 3'd0 || instr_valid !== 1'b0 || fetch_pc !== 32'h300 || imem_req !== 1'b1) begin
      tests_failed++; $display("FAIL ra_pop_flush got cnt=%0d v=%b fpc=%h req=%b exp 0/0/300/1", q_count, instr_valid, fetch_pc, imem_req);
    end
    ack_manual = 1'b1;
    @(negedge clk); ack_manual = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk); redirect_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || fetch_pc !== 32'h0) begin
      tests_failed++; $display("FAIL ra_wrap got req=%b addr=%h fpc=%h exp 1/fffffffc/0", imem_req, imem_addr, fetch_pc);
    end
  endtask

  task automatic test_reset_mid();
    mem_auto = 1'b0; ack_manual = 1'b0; instr_ready = 1'b0;
    do_reset();
    @(negedge clk); ack_manual = 1'b1;
    repeat (2) @(negedge clk); ack_manual = 1'b0;
    @(negedge clk);
    tests_run++; if (q_count !== 3'd2 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL rm_setup got cnt=%0d req=%b exp 2/1", q_count, imem_req); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || q_count !== 3'd0 || fetch_pc !== 32'h0) begin
      tests_failed++; $display("FAIL rm_async got req=%b v=%b cnt=%0d fpc=%h exp 0/0/0/0", imem_req, instr_valid, q_count, fetch_pc);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_pc !== 32'h4) begin
      tests_failed++; $display("FAIL rm_restart got req=%b addr=%h fpc=%h exp 1/0/4", imem_req, imem_addr, fetch_pc);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_auto = 1'b1; ack_manual = 1'b0; mem_lat = 0;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_latency();
    test_redirect_drop();
    test_redirect_ack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
